// File: rtl/wb_retire_queue.sv
// wb_retire_queue: in-order write-back retire queue between MEM and the
// register file. Accepts one MEM result per cycle (valid/allowin), picks the
// final result at enqueue, retires at most one entry per cycle into the
// regfile write port (paused by rf_stall), and exposes two forwarding query
// ports that return the youngest pending value for a register.
// Optional feature macro: WB_TRACE_EN adds the debug_wb_* trace ports and the
// per-entry PC storage that feeds them.
module wb_retire_queue #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              ms_valid,
  output logic              wb_allowin,
  input  logic [DATA_W-1:0] ms_pc,
  input  logic              ms_gr_we,
  input  logic [REG_AW-1:0] ms_dest,
  input  logic [DATA_W-1:0] ms_mem_result,
  input  logic [DATA_W-1:0] ms_alu_result,
  input  logic              ms_rfrom_mem,
  input  logic              rf_stall,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic [REG_AW-1:0] q_raddr1,
  input  logic [REG_AW-1:0] q_raddr2,
  output logic              q_hit1,
  output logic              q_hit2,
  output logic [DATA_W-1:0] q_data1,
  output logic [DATA_W-1:0] q_data2
`ifdef WB_TRACE_EN
  ,
  output logic [DATA_W-1:0] debug_wb_pc,
  output logic [3:0]        debug_wb_rf_we,
  output logic [REG_AW-1:0] debug_wb_rf_wnum,
  output logic [DATA_W-1:0] debug_wb_rf_wdata
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DEPTH-1:0]  we_q, we_d;
  logic [REG_AW-1:0] dest_q   [DEPTH];
  logic [REG_AW-1:0] dest_d   [DEPTH];
  logic [DATA_W-1:0] result_q [DEPTH];
  logic [DATA_W-1:0] result_d [DEPTH];
`ifdef WB_TRACE_EN
  logic [DATA_W-1:0] pc_q     [DEPTH];
  logic [DATA_W-1:0] pc_d     [DEPTH];
`else
  // PC is only needed for the trace port; keep the input but drop its storage.
  logic unused_ms_pc;
  assign unused_ms_pc = ^ms_pc;
`endif

  logic enq;
  logic deq;

  // Handshake, pointer/count arithmetic and the entry write at the tail.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch, so
    // no path leaves a value unassigned and no latch is inferred.
    deq        = (count_q != '0) && !rf_stall;
    wb_allowin = (count_q < DEPTH_C) || deq;
    enq        = ms_valid && wb_allowin;

    wr_ptr_d = wr_ptr_q + PTR_W'(enq);
    rd_ptr_d = rd_ptr_q + PTR_W'(deq);
    count_d  = count_q + CNT_W'(enq) - CNT_W'(deq);

    we_d     = we_q;
    dest_d   = dest_q;
    result_d = result_q;
`ifdef WB_TRACE_EN
    pc_d     = pc_q;
`endif
    if (enq) begin
      we_d[wr_ptr_q]     = ms_gr_we && (ms_dest != '0);
      dest_d[wr_ptr_q]   = ms_dest;
      result_d[wr_ptr_q] = ms_rfrom_mem ? ms_mem_result : ms_alu_result;
`ifdef WB_TRACE_EN
      pc_d[wr_ptr_q]     = ms_pc;
`endif
    end
  end

  // State registers; reset discards every pending entry.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so all
    // flops sample their _d values from the same pre-edge snapshot.
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      we_q     <= '0;
      // NOTE: entry storage is cleared on reset on purpose: the head fields
      // drive rf_waddr/rf_wdata/debug ports, which must read zero after reset.
      for (int i = 0; i < DEPTH; i++) begin
        dest_q[i]   <= '0;
        result_q[i] <= '0;
`ifdef WB_TRACE_EN
        pc_q[i]     <= '0;
`endif
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      we_q     <= we_d;
      for (int i = 0; i < DEPTH; i++) begin
        dest_q[i]   <= dest_d[i];
        result_q[i] <= result_d[i];
`ifdef WB_TRACE_EN
        pc_q[i]     <= pc_d[i];
`endif
      end
    end
  end

  // Regfile write port is driven straight from the head entry.
  always_comb begin
    rf_we    = deq && we_q[rd_ptr_q];
    rf_waddr = dest_q[rd_ptr_q];
    rf_wdata = result_q[rd_ptr_q];
  end

  // Forwarding lookup: walk oldest to youngest so the youngest match wins.
  always_comb begin
    logic [PTR_W-1:0] idx;
    logic             live;
    q_hit1  = 1'b0;
    q_data1 = '0;
    q_hit2  = 1'b0;
    q_data2 = '0;
    idx     = '0;
    live    = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      idx  = rd_ptr_q + PTR_W'(i);
      live = (CNT_W'(i) < count_q) && we_q[idx];
      if (live && (q_raddr1 != '0) && (dest_q[idx] == q_raddr1)) begin
        q_hit1  = 1'b1;
        q_data1 = result_q[idx];
      end
      if (live && (q_raddr2 != '0) && (dest_q[idx] == q_raddr2)) begin
        q_hit2  = 1'b1;
        q_data2 = result_q[idx];
      end
    end
  end

`ifdef WB_TRACE_EN
  // Trace mirrors the retire port; meaningful only on retire cycles.
  always_comb begin
    debug_wb_pc       = pc_q[rd_ptr_q];
    debug_wb_rf_we    = {4{rf_we}};
    debug_wb_rf_wnum  = rf_waddr;
    debug_wb_rf_wdata = rf_wdata;
  end
`endif

endmodule
